// File: rtl/ram_bist_pkg.sv
// Shared types and the address-derived test pattern for the RAM self-test initiator.
package ram_bist_pkg;

   localparam int unsigned MAX_DATA_W = 64;

   typedef enum logic [2:0] {
      IDLE,
      W0,
      R0,
      W1,
      R1,
      DONE
   } state_t;

   // Address bits repeated from the LSB upward, truncated to data_w bits.
   function automatic logic [MAX_DATA_W-1:0] pattern(input logic [MAX_DATA_W-1:0] a,
                                                     input int unsigned addr_w,
                                                     input int unsigned data_w);
      logic [MAX_DATA_W-1:0] p;
      p = '0;
      for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
         if (i < data_w) begin
            p[6'(i)] = a[6'(i % addr_w)];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/ram_bist.sv
// RAM built-in self-test: writes P(a), reads it back, repeats with ~P(a),
// and records the first failing address and the word read there.
module ram_bist
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] ram_out,
   output logic [DATA_W-1:0] ram_in,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_load,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_t            state;
   logic [ADDR_W-1:0] addr_nxt_c;
   logic [DATA_W-1:0] pat_cur_c;
   logic [DATA_W-1:0] pat_nxt_c;
   logic [DATA_W-1:0] exp_c;
   logic              last_c;
   logic              mismatch_c;

   // Expected word for the address on the bus and pattern for the next address.
   always_comb begin
      addr_nxt_c = ram_addr + 1'b1;
      last_c     = (ram_addr == LAST_ADDR);
      pat_cur_c  = DATA_W'(pattern(MAX_DATA_W'(ram_addr), ADDR_W, DATA_W));
      pat_nxt_c  = DATA_W'(pattern(MAX_DATA_W'(addr_nxt_c), ADDR_W, DATA_W));
      exp_c      = (state == R1) ? ~pat_cur_c : pat_cur_c;
      mismatch_c = (ram_out != exp_c);
   end

   // Sequencer; every output is registered together with the state it belongs to.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         ram_in    <= '0;
         ram_addr  <= '0;
         ram_load  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= W0;
                  ram_addr  <= '0;
                  ram_in    <= '0;
                  ram_load  <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_addr <= '0;
                  fail_data <= '0;
               end
            end
            W0, W1: begin
               if (last_c) begin
                  state    <= (state == W0) ? R0 : R1;
                  ram_addr <= '0;
                  ram_in   <= '0;
                  ram_load <= 1'b0;
               end else begin
                  ram_addr <= addr_nxt_c;
                  ram_in   <= (state == W0) ? pat_nxt_c : ~pat_nxt_c;
               end
            end
            R0, R1: begin
               if (mismatch_c) begin
                  state     <= DONE;
                  ram_addr  <= '0;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  pass      <= 1'b0;
                  fail_addr <= ram_addr;
                  fail_data <= ram_out;
               end else if (last_c) begin
                  ram_addr <= '0;
                  if (state == R0) begin
                     state    <= W1;
                     ram_load <= 1'b1;
                     ram_in   <= '1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= 1'b1;
                  end
               end else begin
                  ram_addr <= addr_nxt_c;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_bist.sv
// Self-checking bench: ram_bist driving an 8-word RAM model with optional stuck-at fault.
module tb_ram_bist;

   localparam int unsigned ADDR_W = 3;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned DEPTH  = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [DATA_W-1:0] ram_out;
   logic [DATA_W-1:0] ram_in;
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_load;
   logic              busy;
   logic              done;
   logic              pass;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_data;

   int n_checks = 0;
   int n_errors = 0;

   logic              f_en;
   logic [ADDR_W-1:0] f_addr;
   logic [3:0]        f_bit;
   logic              f_val;
   logic [DATA_W-1:0] mem [DEPTH];

   always #5 clk = ~clk;

   ram_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .ram_out   (ram_out),
      .ram_in    (ram_in),
      .ram_addr  (ram_addr),
      .ram_load  (ram_load),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .fail_addr (fail_addr),
      .fail_data (fail_data)
   );

   // ram8 behaviour: clocked write, combinational read, optional stuck bit.
   always @(posedge clk) begin
      if (ram_load) mem[ram_addr] <= ram_in;
   end

   always_comb begin
      ram_out = mem[ram_addr];
      if (f_en && ram_addr == f_addr) ram_out[f_bit] = f_val;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_pat(input int a);
      logic [DATA_W-1:0] w;
      w = '0;
      for (int k = 0; k < int'(DATA_W); k += int'(ADDR_W)) w |= DATA_W'(a << k);
      return w;
   endfunction

   // Outcome of a whole run derived from the fault and the two-phase pattern rules.
   task automatic model(output logic m_pass, output int m_faddr, output int m_fdata,
                        output int m_busy, output int m_loads);
      logic [DATA_W-1:0] w, r;
      bit found;
      found   = 1'b0;
      m_pass  = 1'b1;
      m_faddr = 0;
      m_fdata = 0;
      m_busy  = 4 * DEPTH;
      m_loads = 2 * DEPTH;
      for (int ph = 0; ph < 2; ph++) begin
         for (int a = 0; a < int'(DEPTH); a++) begin
            w = (ph == 0) ? ref_pat(a) : ~ref_pat(a);
            r = w;
            if (f_en && a == int'(f_addr)) r[f_bit] = f_val;
            if (!found && r != w) begin
               found   = 1'b1;
               m_pass  = 1'b0;
               m_faddr = a;
               m_fdata = int'(r);
               m_busy  = DEPTH + ph * 2 * DEPTH + a + 1;
               m_loads = DEPTH * (ph + 1);
            end
         end
      end
   endtask

   task automatic check_idle(input string tag);
      check_val({tag, "_outs"},
                32'({ram_in, ram_addr, ram_load, busy, done, pass, fail_addr, fail_data}), 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic run_test(input string tag, input bit poke_busy);
      logic m_pass;
      int m_faddr, m_fdata, m_busy, m_loads;
      int busy_n, load_n, cyc, ph, a;
      logic [DATA_W-1:0] exp_in;
      model(m_pass, m_faddr, m_fdata, m_busy, m_loads);
      busy_n = 0;
      load_n = 0;
      cyc    = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      check_val({tag, "_first"}, 32'({done, busy}), 32'b01);
      while (!done && cyc < 200) begin
         if (busy) begin
            busy_n++;
            ph = (cyc / int'(DEPTH)) % 4;
            a  = cyc % int'(DEPTH);
            case (ph)
               0:       exp_in = ref_pat(a);
               2:       exp_in = ~ref_pat(a);
               default: exp_in = '0;
            endcase
            check_val({tag, "_addr"}, 32'(ram_addr), 32'(a));
            check_val({tag, "_in"}, 32'(ram_in), 32'(exp_in));
         end
         if (ram_load) load_n++;
         start = (poke_busy && cyc == 4);
         cyc++;
         @(negedge clk);
      end
      start = 1'b0;
      check_val({tag, "_done"}, 32'(done), 32'd1);
      check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
      check_val({tag, "_load_end"}, 32'(ram_load), 32'd0);
      check_val({tag, "_pass"}, 32'(pass), 32'(m_pass));
      check_val({tag, "_fail_addr"}, 32'(fail_addr), 32'(m_faddr));
      check_val({tag, "_fail_data"}, 32'(fail_data), 32'(m_fdata));
      check_val({tag, "_busy_cycles"}, 32'(busy_n), 32'(m_busy));
      check_val({tag, "_load_cycles"}, 32'(load_n), 32'(m_loads));
      repeat (2) @(negedge clk);
      check_val({tag, "_hold"}, 32'({done, pass, busy, ram_load}), 32'({1'b1, m_pass, 2'b00}));
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      f_en   = 1'b0;
      f_addr = '0;
      f_bit  = '0;
      f_val  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_idle("reset");

      run_test("good", 1'b0);

      f_en = 1'b1; f_addr = 3'd5; f_bit = 4'd0;  f_val = 1'b0;
      run_test("sa0_a5_b0", 1'b0);
      f_addr = 3'd0; f_bit = 4'd15; f_val = 1'b1;
      run_test("sa1_a0_b15", 1'b0);
      f_addr = 3'd7; f_bit = 4'd0;  f_val = 1'b1;
      run_test("sa1_a7_b0", 1'b0);

      // Reset in cycle 10 of a good run.
      f_en = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk) reset = 1'b0;
      check_idle("mid_reset");
      @(negedge clk);
      check_idle("mid_reset_hold");
      run_test("after_reset_poke", 1'b1);

      // Reset and start on the same edge: reset wins.
      @(negedge clk) begin reset = 1'b1; start = 1'b1; end
      @(negedge clk) begin reset = 1'b0; start = 1'b0; end
      check_idle("reset_vs_start");
      @(negedge clk);
      check_idle("reset_vs_start_hold");

      for (int i = 0; i < 12; i++) begin
         f_en   = ($urandom_range(0, 3) != 0);
         f_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
         f_bit  = 4'($urandom_range(0, DATA_W - 1));
         f_val  = 1'($urandom_range(0, 1));
         run_test("rand", 1'($urandom_range(0, 1)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
